// File: rtl/riscv_soft_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_soft_host_arbiter
//  Description : Two-requester arbiter for the riscv_soft_tile host port.
//                Accepts one request at a time, holds it on the tile port
//                until the tile accepts it, and routes the response back to
//                the owning requester. A response timeout forces completion,
//                and a sticky error flag records protocol violations.
//                Define RISCV_SOFT_HOST_ARB_RR_EN for round-robin arbitration;
//                the default is fixed priority with requester 0 winning ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_soft_host_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               S_AXI_ACLK,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [2:0]         req0_op_type,
    input  logic [XPR_LEN-1:0] req0_addr,
    input  logic [XPR_LEN-1:0] req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [2:0]         req1_op_type,
    input  logic [XPR_LEN-1:0] req1_addr,
    input  logic [XPR_LEN-1:0] req1_data,
    output logic               resp0_valid,
    output logic [XPR_LEN-1:0] resp0_data,
    output logic               resp1_valid,
    output logic [XPR_LEN-1:0] resp1_data,
    output logic               host_req_valid,
    input  logic               host_req_ready,
    output logic [1:0]         host_req_op,
    output logic [2:0]         host_req_op_type,
    output logic [XPR_LEN-1:0] host_req_addr,
    output logic [XPR_LEN-1:0] host_req_data,
    input  logic               host_resp_valid,
    input  logic [XPR_LEN-1:0] host_resp_data,
    output logic               err,
    output logic               timeout
);

    localparam int                 c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic [1:0]           op_q, op_d;
    logic [2:0]           op_type_q, op_type_d;
    logic [XPR_LEN-1:0]   addr_q, addr_d;
    logic [XPR_LEN-1:0]   data_q, data_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 grant;
    logic                 handshake;
    logic                 resp_fire;
    logic [XPR_LEN-1:0]   resp_payload;

    // The held request drives the tile port; it only changes on an accept.
    assign host_req_op      = op_q;
    assign host_req_op_type = op_type_q;
    assign host_req_addr    = addr_q;
    assign host_req_data    = data_q;
    assign err              = err_q;

    // Select the winning requester (grant = 1 means requester 1).
    always_comb begin
`ifdef RISCV_SOFT_HOST_ARB_RR_EN
        grant = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
`else
        grant = ~req0_valid;
`endif
    end

    // Next-state, holding-register and output decode for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        op_type_d    = op_type_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        handshake    = 1'b0;
        resp_fire    = 1'b0;
        resp_payload = '0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        host_req_valid = 1'b0;
        timeout      = 1'b0;

        // Outputs are held quiet while reset is asserted so an in-flight
        // transaction is abandoned without a response pulse.
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    handshake  = grant ? req1_valid : req0_valid;
                    req0_ready = req0_valid && !grant;
                    req1_ready = req1_valid && grant;
                    if (handshake) begin
                        owner_d      = grant;
                        last_grant_d = grant;
                        op_d         = grant ? req1_op      : req0_op;
                        op_type_d    = grant ? req1_op_type : req0_op_type;
                        addr_d       = grant ? req1_addr    : req0_addr;
                        data_d       = grant ? req1_data    : req0_data;
                        state_d      = ST_ISSUE;
                    end
                    if (host_resp_valid) begin
                        err_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    host_req_valid = 1'b1;
                    if (host_req_ready) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_RESP;
                    end
                    if (host_resp_valid) begin
                        err_d = 1'b1;
                    end
                end
                ST_WAIT_RESP: begin
                    // A real response takes precedence over timeout expiry.
                    if (host_resp_valid) begin
                        resp_fire    = 1'b1;
                        resp_payload = host_resp_data;
                        state_d      = ST_IDLE;
                    end else if (cnt_q == c_cnt_last) begin
                        resp_fire = 1'b1;
                        timeout   = 1'b1;
                        err_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        resp0_valid = resp_fire && !owner_q;
        resp1_valid = resp_fire && owner_q;
        resp0_data  = resp0_valid ? resp_payload : '0;
        resp1_data  = resp1_valid ? resp_payload : '0;
    end

    // State and holding registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            op_type_q    <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            op_type_q    <= op_type_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_soft_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_soft_host_arbiter
//  Description : Self-checking bench for riscv_soft_host_arbiter with a
//                transaction-level reference model (TIMEOUT_CYCLES = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_soft_host_arbiter;

    localparam int TO = 8;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  ot;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [2:0]  req0_op_type = '0, req1_op_type = '0;
    logic [31:0] req0_addr = '0, req1_addr = '0, req0_data = '0, req1_data = '0;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_data, resp1_data;
    logic        host_req_valid;
    logic        host_req_ready = 1'b0;
    logic [1:0]  host_req_op;
    logic [2:0]  host_req_op_type;
    logic [31:0] host_req_addr, host_req_data;
    logic        host_resp_valid = 1'b0;
    logic [31:0] host_resp_data = '0;
    logic        err, timeout;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: who won last, and the expected sticky error.
    logic m_last = 1'b1;
    logic m_err  = 1'b0;

    riscv_soft_host_arbiter #(.XPR_LEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .S_AXI_ACLK(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_op_type(req0_op_type), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_op_type(req1_op_type), .req1_addr(req1_addr), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_op_type(host_req_op_type),
        .host_req_addr(host_req_addr), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
        .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: a lone requester wins; on a tie, fixed priority
    // favours 0, round-robin favours whoever did not win last time.
    function automatic logic model_grant(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef RISCV_SOFT_HOST_ARB_RR_EN
            return !m_last;
`else
            return 1'b0;
`endif
        end
        return v0 ? 1'b0 : 1'b1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.op   = 2'($urandom_range(1, 2));
        r.ot   = 3'($urandom_range(0, 5));
        r.addr = $urandom;
        r.data = $urandom;
        return r;
    endfunction

    // One idle cycle, optionally with a stray tile response.
    task automatic idle_cycle(input logic pulse_resp);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; host_req_ready = 1'b0;
        host_resp_valid = pulse_resp; host_resp_data = $urandom;
        #1;
        chk("idle_err", err, m_err);
        chk("idle_resp0_valid", resp0_valid, 1'b0);
        chk("idle_resp1_valid", resp1_valid, 1'b0);
        chk("idle_timeout", timeout, 1'b0);
        chk("idle_host_req_valid", host_req_valid, 1'b0);
        if (pulse_resp) m_err = 1'b1;
    endtask

    // Full transaction: accept, rdy_dly stalled issue cycles, then a response
    // on WAIT cycle rsp_dly (negative = tile never answers).
    task automatic do_txn(input logic v0, input logic v1, input req_t r0, input req_t r1,
                          input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                          output logic owner);
        logic g;
        req_t w;
        logic done;
        logic exp_v;
        logic [31:0] exp_d;
        logic exp_to;
        @(negedge clk);
        req0_valid = v0; req0_op = r0.op; req0_op_type = r0.ot; req0_addr = r0.addr; req0_data = r0.data;
        req1_valid = v1; req1_op = r1.op; req1_op_type = r1.ot; req1_addr = r1.addr; req1_data = r1.data;
        host_req_ready = 1'b0; host_resp_valid = 1'b0;
        #1;
        g = model_grant(v0, v1);
        w = g ? r1 : r0;
        chk("err_before_accept", err, m_err);
        chk("req0_ready_accept", req0_ready, !g);
        chk("req1_ready_accept", req1_ready, g);
        chk("host_req_valid_idle", host_req_valid, 1'b0);
        m_last = g;
        owner  = g;
        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk);
            if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
            host_req_ready = (k == rdy_dly);
            #1;
            chk("issue_valid", host_req_valid, 1'b1);
            chk("issue_op", host_req_op, w.op);
            chk("issue_op_type", host_req_op_type, w.ot);
            chk("issue_addr", host_req_addr, w.addr);
            chk("issue_data", host_req_data, w.data);
            chk("issue_req0_ready", req0_ready, 1'b0);
            chk("issue_req1_ready", req1_ready, 1'b0);
            chk("issue_resp_any", resp0_valid | resp1_valid, 1'b0);
        end
        done = 1'b0;
        for (int c = 0; c < TO && !done; c++) begin
            @(negedge clk);
            host_req_ready  = 1'b0;
            host_resp_valid = (c == rsp_dly);
            host_resp_data  = (c == rsp_dly) ? rdata : $urandom;
            #1;
            if (c == rsp_dly) begin
                exp_v = 1'b1; exp_d = rdata; exp_to = 1'b0; done = 1'b1;
            end else if (c == TO - 1) begin
                exp_v = 1'b1; exp_d = '0; exp_to = 1'b1; done = 1'b1; m_err = 1'b1;
            end else begin
                exp_v = 1'b0; exp_d = '0; exp_to = 1'b0;
            end
            chk("wait_owner_valid", g ? resp1_valid : resp0_valid, exp_v);
            chk("wait_owner_data",  g ? resp1_data  : resp0_data,  exp_d);
            chk("wait_other_valid", g ? resp0_valid : resp1_valid, 1'b0);
            chk("wait_timeout", timeout, exp_to);
            chk("wait_req_ready", req0_ready | req1_ready, 1'b0);
        end
    endtask

    initial begin
        req_t  ra, rb, rz;
        logic  own;
        logic [3:0] tie_exp;
        logic [1:0] sel;
        int    rdy, rsp, rr;

        rz = '{op: 2'd0, ot: 3'd0, addr: 32'd0, data: 32'd0};

        // Reset state.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_host_req_valid", host_req_valid, 1'b0);
        chk("rst_host_req_addr", host_req_addr, 32'd0);
        chk("rst_host_req_data", host_req_data, 32'd0);
        chk("rst_resp0_data", resp0_data, 32'd0);
        chk("rst_resp1_data", resp1_data, 32'd0);
        chk("rst_resp_valid", resp0_valid | resp1_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_timeout", timeout, 1'b0);

        // Tie: both requesters valid for four transactions.
`ifdef RISCV_SOFT_HOST_ARB_RR_EN
        tie_exp = 4'b1010;
`else
        tie_exp = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            ra = rand_req(); rb = rand_req();
            do_txn(1'b1, 1'b1, ra, rb, 0, 0, $urandom, own);
            chk("tie_grant", own, tie_exp[i]);
        end
        idle_cycle(1'b0);

        // Single load from requester 0.
        ra = '{op: 2'd1, ot: 3'd2, addr: 32'h100, data: 32'd0};
        do_txn(1'b1, 1'b0, ra, rz, 0, 1, 32'hCAFEF00D, own);
        idle_cycle(1'b0);

        // Backpressure: requester 1 store held for 5 stalled cycles.
        rb = '{op: 2'd2, ot: 3'd2, addr: 32'h200, data: 32'h12345678};
        do_txn(1'b0, 1'b1, rz, rb, 5, 0, 32'h0, own);

        // Response arriving on the last counter cycle beats the timeout.
        ra = rand_req();
        do_txn(1'b1, 1'b0, ra, rz, 1, TO - 1, 32'h5A5A1234, own);
        idle_cycle(1'b0);

        // Unexpected response while idle.
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Reset in WAIT_RESP with the tile answering during reset.
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 32'h300; req0_op = 2'd1;
        #1; chk("rmid_accept", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0; host_req_ready = 1'b1;
        #1; chk("rmid_issue", host_req_valid, 1'b1);
        @(negedge clk);
        host_req_ready = 1'b0;
        #1; chk("rmid_wait", resp0_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1; host_resp_valid = 1'b1; host_resp_data = 32'hDEADBEEF;
        #1; chk("rmid_resp_during_reset", resp0_valid | resp1_valid, 1'b0);
        @(negedge clk);
        #1; chk("rmid_resp_during_reset2", resp0_valid | resp1_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0; host_resp_valid = 1'b0;
        m_err = 1'b0; m_last = 1'b1;
        #1;
        chk("rmid_err_cleared", err, 1'b0);
        chk("rmid_idle", host_req_valid, 1'b0);
        ra = rand_req();
        do_txn(1'b1, 1'b0, ra, rz, 0, 0, 32'h600DF00D, own);

        // Timeout: the tile never answers.
        ra = rand_req();
        do_txn(1'b1, 1'b0, ra, rz, 0, -1, 32'h0, own);
        idle_cycle(1'b0);
        ra = rand_req();
        do_txn(1'b1, 1'b0, ra, rz, 0, 2, $urandom, own);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            sel = 2'($urandom_range(1, 3));
            ra  = rand_req(); rb = rand_req();
            rdy = $urandom_range(0, 3);
            rr  = $urandom_range(0, 9);
            rsp = (rr >= TO) ? -1 : rr;
            do_txn(sel[0], sel[1], ra, rb, rdy, rsp, $urandom, own);
            if ($urandom_range(0, 7) == 0) idle_cycle(1'b1);
        end
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
